// File: rtl/multicycle_ctrl_if.sv
// Control-unit bundle: instruction fields and memory status in, datapath selects and status out.
// master drives the instruction side; slave is the controller.
interface multicycle_ctrl_if;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        mem_ready;
    logic        pc_write;
    logic        ir_write;
    logic        adr_src;
    logic        reg_write;
    logic [1:0]  result_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        Imm_Src;
    logic        illegal;
    logic [15:0] retired;

    modport master (
        output op, funct3, funct7b5, mem_ready,
        input  pc_write, ir_write, adr_src, reg_write, result_src,
        input  alu_src_a, alu_src_b, alu_op, Imm_Src, illegal, retired
    );

    modport slave (
        input  op, funct3, funct7b5, mem_ready,
        output pc_write, ir_write, adr_src, reg_write, result_src,
        output alu_src_a, alu_src_b, alu_op, Imm_Src, illegal, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle RV32 subset (lw, R-type, I-ALU, lui) with retire counter.
// Optional MEM_WAIT_EN: FETCH and MEMREAD stall until mem_ready.
module multicycle_ctrl (
    input  logic             clk,
    input  logic             rst,
    multicycle_ctrl_if.slave ctrl
);
    localparam int unsigned RetW = 16;

    localparam logic [6:0] OpLoad = 7'b0000011;
    localparam logic [6:0] OpReg  = 7'b0110011;
    localparam logic [6:0] OpImm  = 7'b0010011;
    localparam logic [6:0] OpLui  = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_EXECR, S_EXECI, S_LUI, S_ALUWB, S_TRAP
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       adr_src;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       imm_src;
    } ctrl_t;

    function automatic state_t next_of(input state_t s, input logic [6:0] op, input logic ready);
        state_t n;
        n = S_TRAP;
        case (s)
            S_FETCH:   n = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OpLoad:  n = S_MEMADR;
                    OpReg:   n = S_EXECR;
                    OpImm:   n = S_EXECI;
                    OpLui:   n = S_LUI;
                    default: n = S_TRAP;
                endcase
            end
            S_MEMADR:  n = S_MEMREAD;
            S_MEMREAD: n = ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:   n = S_FETCH;
            S_EXECR:   n = S_ALUWB;
            S_EXECI:   n = S_ALUWB;
            S_LUI:     n = S_ALUWB;
            S_ALUWB:   n = S_FETCH;
            default:   n = S_TRAP;
        endcase
        return n;
    endfunction

    // Per-state datapath control word; anything not set stays 0.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.result_src = 2'b10;
                c.alu_src_b  = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_LUI: begin
                c.alu_src_a = 2'b11;
                c.alu_src_b = 2'b01;
                c.imm_src   = 1'b1;
            end
            S_ALUWB:  c.reg_write = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t          r_state;
    ctrl_t           r_ctrl;
    logic            r_illegal;
    logic [RetW-1:0] r_retired;

    logic   w_mem_ok;
    state_t w_next;
    logic   w_retire;
    logic   w_unused_ok;

`ifdef MEM_WAIT_EN
    assign w_mem_ok = ctrl.mem_ready;
`else
    assign w_mem_ok = 1'b1;
`endif

    // funct fields belong to the ALU decoder; mem_ready matters only with stalls enabled.
    assign w_unused_ok = ^{ctrl.funct3, ctrl.funct7b5, ctrl.mem_ready};

    assign w_next   = next_of(r_state, ctrl.op, w_mem_ok);
    assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB);

    // Control word is registered against the state being entered, so it always matches r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_ctrl    <= ctrl_of(S_FETCH);
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_of(w_next);
            if (w_next == S_TRAP) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + RetW'(1);
            end
        end
    end

    // Write enables are suppressed while reset is high and while a fetch is stalled.
    assign ctrl.pc_write   = r_ctrl.pc_write & ~rst & w_mem_ok;
    assign ctrl.ir_write   = r_ctrl.ir_write & ~rst & w_mem_ok;
    assign ctrl.reg_write  = r_ctrl.reg_write & ~rst;
    assign ctrl.adr_src    = r_ctrl.adr_src;
    assign ctrl.result_src = r_ctrl.result_src;
    assign ctrl.alu_src_a  = r_ctrl.alu_src_a;
    assign ctrl.alu_src_b  = r_ctrl.alu_src_b;
    assign ctrl.alu_op     = r_ctrl.alu_op;
    assign ctrl.Imm_Src    = r_ctrl.imm_src;
    assign ctrl.illegal    = r_illegal;
    assign ctrl.retired    = r_retired;
endmodule
